// File: rtl/axi_arbiter.sv
// Merges the i_cache read port and the d_cache read/write ports onto one AXI master.
// Optional read-after-write address hazard check enabled by defining ARB_RAW_CHECK_EN.
module axi_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter logic [3:0]  ID_I       = 4'd0,
  parameter logic [3:0]  ID_D       = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  // i_cache read port
  input  logic [31:0] i_araddr,
  input  logic [7:0]  i_arlen,
  input  logic        i_arvalid,
  output logic        i_arready,
  output logic [31:0] i_rdata,
  output logic        i_rlast,
  output logic        i_rvalid,
  input  logic        i_rready,
  // d_cache read port
  input  logic [31:0] d_araddr,
  input  logic [7:0]  d_arlen,
  input  logic        d_arvalid,
  output logic        d_arready,
  output logic [31:0] d_rdata,
  output logic        d_rlast,
  output logic        d_rvalid,
  input  logic        d_rready,
  // d_cache write port
  input  logic [31:0] d_awaddr,
  input  logic [7:0]  d_awlen,
  input  logic [2:0]  d_awsize,
  input  logic        d_awvalid,
  output logic        d_awready,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  input  logic        d_wlast,
  input  logic        d_wvalid,
  output logic        d_wready,
  output logic        d_bvalid,
  input  logic        d_bready,
  // AXI master
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_ADDR = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_BUSY = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [7:0] STARVE_LIM = STARVE_MAX[7:0];

  logic [1:0]  r_state_q, r_state_d;
  logic        sel_d_q, sel_d_d;
  logic [7:0]  starve_q, starve_d;
  logic [31:0] ar_addr_q, ar_addr_d;
  logic [7:0]  ar_len_q, ar_len_d;

  logic [1:0]  w_state_q, w_state_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;

  logic        d_req, pick_i, pick_d;

  // rid/rresp/bid/bresp carry nothing this core acts on.
  logic        unused_resp;
  assign unused_resp = ^{rid, rresp, bid, bresp};

`ifdef ARB_RAW_CHECK_EN
  logic [29:0] aw_word_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_word_q <= '0;
    end else if (w_state_q == W_IDLE && d_awvalid) begin
      aw_word_q <= d_awaddr[31:2];
    end
  end

  // Hold a d read that would overtake a pending write to the same word.
  assign d_req = d_arvalid && !((w_state_q != W_IDLE) && (d_araddr[31:2] == aw_word_q));
`else
  assign d_req = d_arvalid;
`endif

  assign pick_i = i_arvalid && (!d_req || starve_q == STARVE_LIM);
  assign pick_d = !pick_i && d_req;

  always_comb begin
    r_state_d = r_state_q;
    sel_d_d   = sel_d_q;
    starve_d  = starve_q;
    ar_addr_d = ar_addr_q;
    ar_len_d  = ar_len_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (pick_i) begin
          r_state_d = R_ADDR;
          sel_d_d   = 1'b0;
          starve_d  = '0;
          ar_addr_d = i_araddr;
          ar_len_d  = i_arlen;
        end else if (pick_d) begin
          r_state_d = R_ADDR;
          sel_d_d   = 1'b1;
          ar_addr_d = d_araddr;
          ar_len_d  = d_arlen;
          if (i_arvalid && starve_q != STARVE_LIM) starve_d = starve_q + 8'd1;
        end
      end
      R_ADDR: if (arready) r_state_d = R_DATA;
      R_DATA: if (rvalid && rready && rlast) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_q <= R_IDLE;
      sel_d_q   <= 1'b1;
      starve_q  <= '0;
      ar_addr_q <= '0;
      ar_len_q  <= '0;
    end else begin
      r_state_q <= r_state_d;
      sel_d_q   <= sel_d_d;
      starve_q  <= starve_d;
      ar_addr_q <= ar_addr_d;
      ar_len_q  <= ar_len_d;
    end
  end

  assign arid      = sel_d_q ? ID_D : ID_I;
  assign araddr    = ar_addr_q;
  assign arlen     = ar_len_q;
  assign arsize    = 3'b010;
  assign arburst   = 2'b01;
  assign arvalid   = (r_state_q == R_ADDR);
  assign d_arready = arvalid && sel_d_q && arready;
  assign i_arready = arvalid && !sel_d_q && arready;
  assign rready    = (r_state_q == R_DATA) && (sel_d_q ? d_rready : i_rready);
  assign d_rvalid  = (r_state_q == R_DATA) && sel_d_q && rvalid;
  assign i_rvalid  = (r_state_q == R_DATA) && !sel_d_q && rvalid;
  assign d_rdata   = rdata;
  assign i_rdata   = rdata;
  assign d_rlast   = rlast;
  assign i_rlast   = rlast;

  always_comb begin
    w_state_d = w_state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    unique case (w_state_q)
      W_IDLE: if (d_awvalid) w_state_d = W_BUSY;
      W_BUSY: begin
        if (awvalid && awready) aw_done_d = 1'b1;
        if (wvalid && wready && wlast) w_done_d = 1'b1;
        if (aw_done_d && w_done_d) w_state_d = W_RESP;
      end
      W_RESP: begin
        if (bvalid && bready) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_q <= W_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  assign awid      = ID_D;
  assign awaddr    = d_awaddr;
  assign awlen     = d_awlen;
  assign awsize    = d_awsize;
  assign awburst   = 2'b01;
  assign awvalid   = (w_state_q == W_BUSY) && d_awvalid && !aw_done_q;
  assign d_awready = (w_state_q == W_BUSY) && !aw_done_q && awready;
  assign wid       = ID_D;
  assign wdata     = d_wdata;
  assign wstrb     = d_wstrb;
  assign wlast     = d_wlast;
  assign wvalid    = (w_state_q == W_BUSY) && d_wvalid && !w_done_q;
  assign d_wready  = (w_state_q == W_BUSY) && !w_done_q && wready;
  assign bready    = (w_state_q == W_RESP) && d_bready;
  assign d_bvalid  = (w_state_q == W_RESP) && bvalid;

endmodule

// File: tb/tb_axi_arbiter.sv
// Directed bench for axi_arbiter: arbitration, starvation guard, write path, concurrency,
// optional RAW hold (expectations follow ARB_RAW_CHECK_EN) and async reset mid-burst.
module tb_axi_arbiter;

  logic        clk, rst;
  logic [31:0] i_araddr, d_araddr, i_rdata, d_rdata;
  logic [7:0]  i_arlen, d_arlen;
  logic        i_arvalid, d_arvalid, i_arready, d_arready;
  logic        i_rlast, d_rlast, i_rvalid, d_rvalid, i_rready, d_rready;
  logic [31:0] d_awaddr, d_wdata;
  logic [7:0]  d_awlen;
  logic [2:0]  d_awsize;
  logic        d_awvalid, d_awready, d_wlast, d_wvalid, d_wready, d_bvalid, d_bready;
  logic [3:0]  d_wstrb;
  logic [3:0]  arid, rid, awid, wid, bid, wstrb;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, rresp, awburst, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int n_checks = 0;
  int n_errors = 0;

  axi_arbiter #(.STARVE_MAX(4), .ID_I(4'd0), .ID_D(4'd1)) dut (
    .clk(clk), .rst(rst),
    .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arvalid(i_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rvalid(i_rvalid), .i_rready(i_rready),
    .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arvalid(d_arvalid), .d_arready(d_arready),
    .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rvalid(d_rvalid), .d_rready(d_rready),
    .d_awaddr(d_awaddr), .d_awlen(d_awlen), .d_awsize(d_awsize), .d_awvalid(d_awvalid),
    .d_awready(d_awready), .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_wlast(d_wlast),
    .d_wvalid(d_wvalid), .d_wready(d_wready), .d_bvalid(d_bvalid), .d_bready(d_bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Slave side of one read: wait for arvalid, accept, return `beats` beats.
  task automatic serve_read(input int beats, output logic [3:0] id, output logic [31:0] addr);
    int n = 0;
    @(posedge clk);
    #2;
    while (!arvalid && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    check_eq("ar_wait", (n < 20), 1);
    id   = arid;
    addr = araddr;
    arready = 1'b1;
    #1;
    check_eq("arready_grant", (id == 4'd1) ? d_arready : i_arready, 1);
    check_eq("arready_other", (id == 4'd1) ? i_arready : d_arready, 0);
    step();
    arready = 1'b0;
    for (int b = 0; b < beats; b++) begin
      rvalid = 1'b1;
      rdata  = 32'hA000_0000 + b;
      rlast  = (b == beats - 1);
      #1;
      check_eq("rvalid_grant", (id == 4'd1) ? d_rvalid : i_rvalid, 1);
      check_eq("rvalid_other", (id == 4'd1) ? i_rvalid : d_rvalid, 0);
      check_eq("rdata_pass", (id == 4'd1) ? d_rdata : i_rdata, 32'hA000_0000 + b);
      step();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
  endtask

  logic [3:0]  id;
  logic [31:0] addr;
  logic [3:0]  order [6];

  initial begin
    order = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd0, 4'd1};
    rst = 1'b0;
    {i_araddr, i_arlen, i_arvalid, d_araddr, d_arlen, d_arvalid} = '0;
    {d_awaddr, d_awlen, d_awsize, d_awvalid, d_wdata, d_wstrb, d_wlast, d_wvalid} = '0;
    {arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bid, bresp, bvalid} = '0;
    i_rready = 1'b1;
    d_rready = 1'b1;
    d_bready = 1'b1;
    step();
    step();
    check_eq("rst_arvalid", arvalid, 0);
    check_eq("rst_awvalid", awvalid, 0);
    check_eq("rst_rready", rready, 0);
    check_eq("rst_bready", bready, 0);
    rst = 1'b1;
    step();

    // Simultaneous requests: d first, then i after one idle cycle.
    i_arvalid = 1'b1; i_araddr = 32'h0000_1000; i_arlen = 8'd1;
    d_arvalid = 1'b1; d_araddr = 32'h0000_2000; d_arlen = 8'd3;
    serve_read(4, id, addr);
    check_eq("both_id", id, 1);
    check_eq("both_addr", addr, 32'h0000_2000);
    d_arvalid = 1'b0;
    #1;
    check_eq("idle_gap_arvalid", arvalid, 0);
    serve_read(2, id, addr);
    check_eq("then_i_id", id, 0);
    check_eq("then_i_addr", addr, 32'h0000_1000);
    i_arvalid = 1'b0;
    step();

    // Starvation guard: d,d,d,d,i,d.
    i_arvalid = 1'b1; d_arvalid = 1'b1; d_arlen = 8'd0; i_arlen = 8'd0;
    for (int k = 0; k < 6; k++) begin
      serve_read(1, id, addr);
      check_eq($sformatf("starve_%0d", k), id, order[k]);
    end
    i_arvalid = 1'b0; d_arvalid = 1'b0;
    step();

    // Write: AW accepted cycle 2, W accepted cycle 5.
    d_awaddr = 32'h8000_0040; d_awlen = 8'd0; d_awsize = 3'd2; d_awvalid = 1'b1;
    d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF; d_wlast = 1'b1; d_wvalid = 1'b1;
    #1;
    check_eq("w_idle_awvalid", awvalid, 0);
    step();
    #1;
    check_eq("w_awvalid", awvalid, 1);
    check_eq("w_awaddr", awaddr, 32'h8000_0040);
    check_eq("w_awid", awid, 1);
    check_eq("w_wvalid", wvalid, 1);
    step();
    awready = 1'b1;
    #1;
    check_eq("w_d_awready", d_awready, 1);
    step();
    awready = 1'b0;
    #1;
    check_eq("w_aw_done_gate", awvalid, 0);
    check_eq("w_bready_c3", bready, 0);
    step();
    #1;
    check_eq("w_bready_c4", bready, 0);
    step();
    wready = 1'b1;
    #1;
    check_eq("w_d_wready", d_wready, 1);
    step();
    wready = 1'b0;
    #1;
    check_eq("w_wvalid_gate", wvalid, 0);
    check_eq("w_bready_resp", bready, 1);
    check_eq("w_dbvalid_lo", d_bvalid, 0);
    step();
    bvalid = 1'b1;
    #1;
    check_eq("w_dbvalid_hi", d_bvalid, 1);
    step();
    bvalid = 1'b0; d_awvalid = 1'b0; d_wvalid = 1'b0;
    #1;
    check_eq("w_back_idle", bready, 0);
    step();

    // Concurrent write 0x100 and read 0x200.
    d_awaddr = 32'h100; d_awvalid = 1'b1; d_wvalid = 1'b1;
    d_arvalid = 1'b1; d_araddr = 32'h200;
    step();
    #1;
    check_eq("cc_arvalid", arvalid, 1);
    check_eq("cc_awvalid", awvalid, 1);
    check_eq("cc_araddr", araddr, 32'h200);
    check_eq("cc_awaddr", awaddr, 32'h100);
    arready = 1'b1; awready = 1'b1; wready = 1'b1;
    step();
    arready = 1'b0; awready = 1'b0; wready = 1'b0; d_arvalid = 1'b0;
    rvalid = 1'b1; rlast = 1'b1; rdata = 32'h1234_5678; bvalid = 1'b1;
    #1;
    check_eq("cc_d_rvalid", d_rvalid, 1);
    check_eq("cc_d_bvalid", d_bvalid, 1);
    step();
    rvalid = 1'b0; rlast = 1'b0; bvalid = 1'b0; d_awvalid = 1'b0; d_wvalid = 1'b0;
    step();

    // Read of a word with a pending write.
    d_awaddr = 32'h100; d_awvalid = 1'b1; d_wvalid = 1'b1;
    step();
    d_arvalid = 1'b1; d_araddr = 32'h100; d_arlen = 8'd0;
    step();
    #1;
`ifdef ARB_RAW_CHECK_EN
    check_eq("raw_hold1", arvalid, 0);
`else
    check_eq("raw_nohold", arvalid, 1);
`endif
    awready = 1'b1; wready = 1'b1;
    step();
    awready = 1'b0; wready = 1'b0;
    #1;
`ifdef ARB_RAW_CHECK_EN
    check_eq("raw_hold2", arvalid, 0);
`else
    check_eq("raw_still", arvalid, 1);
`endif
    bvalid = 1'b1;
    step();
    bvalid = 1'b0; d_awvalid = 1'b0; d_wvalid = 1'b0;
    #1;
`ifdef ARB_RAW_CHECK_EN
    check_eq("raw_hold3", arvalid, 0);
`else
    check_eq("raw_still2", arvalid, 1);
`endif
    serve_read(1, id, addr);
    check_eq("raw_id", id, 1);
    check_eq("raw_addr", addr, 32'h100);
    d_arvalid = 1'b0;
    step();

    // Async reset in the middle of a read burst and a write.
    d_arvalid = 1'b1; d_araddr = 32'h300; d_arlen = 8'd3;
    d_awaddr = 32'h400; d_awvalid = 1'b1; d_wvalid = 1'b1;
    step();
    arready = 1'b1;
    step();
    arready = 1'b0; d_arvalid = 1'b0;
    rvalid = 1'b1;
    #1;
    check_eq("mid_d_rvalid", d_rvalid, 1);
    check_eq("mid_awvalid", awvalid, 1);
    rst = 1'b0;
    #1;
    check_eq("arst_d_rvalid", d_rvalid, 0);
    check_eq("arst_rready", rready, 0);
    check_eq("arst_awvalid", awvalid, 0);
    check_eq("arst_wvalid", wvalid, 0);
    step();
    rst = 1'b1;
    #1;
    check_eq("post_rst_arvalid", arvalid, 0);
    check_eq("post_rst_awvalid", awvalid, 0);
    rvalid = 1'b0; d_awvalid = 1'b0; d_wvalid = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
